// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Index width for n requesters (at least one bit)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx
);

    int unsigned   pos;
    logic [IW-1:0] idx;
    logic          found;

    // Scan N positions starting just after last_owner
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        pos        = 0;
        idx        = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            pos = (32'(last_owner) + i) % N;
            idx = IW'(pos);
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding one UART transmitter byte stream.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN (forced release of an idle lock).
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_SRC-1:0][BYTE_W-1:0]  src_data_i,
    input  logic [NUM_SRC-1:0]              src_vld_i,
    input  logic [NUM_SRC-1:0]              src_last_i,
    output logic [NUM_SRC-1:0]              src_rdy_o,
    output logic [BYTE_W-1:0]               uart_tx_data_o,
    output logic                            uart_tx_data_vld_o,
    input  logic                            uart_tx_data_rdy_i,
    output logic [NUM_SRC-1:0]              grant_o,
    output logic                            timeout_o
);

    localparam int unsigned IW = idx_w(NUM_SRC);

    arb_state_t           state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        last_owner;
    logic [NUM_SRC-1:0]   win_oh;
    logic [IW-1:0]        win_idx;
    logic                 owner_vld;
    logic                 owner_last;
    logic [BYTE_W-1:0]    owner_data;
    logic                 slot_free;
    logic                 accept;
    logic                 expire;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req        (src_vld_i),
        .last_owner (last_owner),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // Owner view, ready steering and byte acceptance
    always_comb begin
        owner_vld  = src_vld_i[owner];
        owner_last = src_last_i[owner];
        owner_data = src_data_i[owner];
        slot_free  = ~uart_tx_data_vld_o | uart_tx_data_rdy_i;
        src_rdy_o  = '0;
        if (state == LOCK) begin
            src_rdy_o[owner] = slot_free;
        end
        accept = (state == LOCK) && owner_vld && slot_free;
    end

    // Single-entry output register toward the transmitter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            uart_tx_data_o     <= '0;
            uart_tx_data_vld_o <= 1'b0;
        end else if (accept) begin
            uart_tx_data_o     <= owner_data;
            uart_tx_data_vld_o <= 1'b1;
        end else if (uart_tx_data_rdy_i) begin
            uart_tx_data_vld_o <= 1'b0;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] idle_cnt;

    always_comb begin
        expire = (state == LOCK) && !owner_vld && (idle_cnt == TW'(TIMEOUT_CYC - 1));
    end

    // Count owner-idle lock cycles; the pulse marks a forced release
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= expire;
            if ((state != LOCK) || accept || expire) begin
                idle_cnt <= '0;
            end else if (!owner_vld) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Arbitration FSM: pick in ARB, hold the lock until last (or forced release)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ARB;
            owner      <= '0;
            last_owner <= IW'(NUM_SRC - 1);
            grant_o    <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (|src_vld_i) begin
                        state   <= LOCK;
                        owner   <= win_idx;
                        grant_o <= win_oh;
                    end
                end
                LOCK: begin
                    if ((accept && owner_last) || expire) begin
                        state      <= ARB;
                        last_owner <= owner;
                        grant_o    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed scenarios plus randomized packet traffic.
module tb_uart_tx_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int HOLD_CYC = 5;
`else
    localparam int HOLD_CYC = 20;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0][7:0] src_data;
    logic [N-1:0]      src_vld;
    logic [N-1:0]      src_last;
    logic [N-1:0]      src_rdy;
    logic [7:0]        tx_data;
    logic              tx_vld;
    logic              tx_rdy;
    logic [N-1:0]      grant;
    logic              timeout;

    uart_tx_arb #(
        .NUM_SRC     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .src_data_i         (src_data),
        .src_vld_i          (src_vld),
        .src_last_i         (src_last),
        .src_rdy_o          (src_rdy),
        .uart_tx_data_o     (tx_data),
        .uart_tx_data_vld_o (tx_vld),
        .uart_tx_data_rdy_i (tx_rdy),
        .grant_o            (grant),
        .timeout_o          (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-source packet queues of {last, data}; the driver presents the head
    logic [8:0]   pkt_q [N][$];
    logic [N-1:0] hold = '0;
    int           gap_pct = 0;
    int           rdy_low_pct = 0;
    logic         force_low = 1'b0;

    logic [7:0]   sb [$];
    logic [7:0]   olog_d [$];
    int           olog_c [$];
    logic [N-1:0] glog_v [$];
    int           glog_c [$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit queues_empty();
        for (int s = 0; s < N; s++) if (pkt_q[s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Source and sink driver: inputs change 1 time unit after the rising edge
    initial begin : driver
        logic [N-1:0] fire;
        src_vld = '0; src_last = '0; src_data = '0; tx_rdy = 1'b1;
        forever begin
            @(negedge clk);
            fire = src_vld & src_rdy & {N{~rst}};
            @(posedge clk);
            #1;
            for (int s = 0; s < N; s++) begin
                if (fire[s] && pkt_q[s].size() > 0) void'(pkt_q[s].pop_front());
                if (pkt_q[s].size() > 0 && !hold[s] && int'($urandom_range(99)) >= gap_pct) begin
                    src_vld[s] = 1'b1;
                    {src_last[s], src_data[s]} = pkt_q[s][0];
                end else begin
                    src_vld[s]  = 1'b0;
                    src_last[s] = 1'($urandom);
                    src_data[s] = 8'($urandom);
                end
            end
            tx_rdy = !force_low && (int'($urandom_range(99)) >= rdy_low_pct);
        end
    end

    // Reference model: packet-level arbitration rules, expected bytes into the scoreboard
    initial begin : model
        bit           armed = 0, locked = 0, buf_full = 0, exp_to = 0;
        int           owner = 0, last_owner = N - 1, idle = 0, k = 0;
        logic [N-1:0] v, l, r, g, exp_rdy;
        logic [N-1:0][7:0] d;
        logic         tr, rs, ov, to;
        forever begin
            @(negedge clk);
            v = src_vld; l = src_last; d = src_data; tr = tx_rdy; rs = rst;
            r = src_rdy; g = grant; ov = tx_vld; to = timeout;
            exp_rdy = '0;
            if (locked) exp_rdy[owner] = !buf_full || tr;
            if (armed) begin
                check("grant", 32'(g), locked ? (32'(1) << owner) : 32'(0));
                check("src_rdy", 32'(r), 32'(exp_rdy));
                check("tx_vld", 32'(ov), 32'(buf_full));
                check("timeout", 32'(to), 32'(exp_to));
            end
            #2;
            if (rs) begin
                armed = 1; locked = 0; buf_full = 0; exp_to = 0; idle = 0;
                last_owner = N - 1;
                sb.delete();
            end else begin
                exp_to = 0;
                if (buf_full && tr) buf_full = 0;
                if (locked) begin
                    if (v[owner] && exp_rdy[owner]) begin
                        sb.push_back(d[owner]);
                        buf_full = 1;
                        idle = 0;
                        if (l[owner]) begin locked = 0; last_owner = owner; end
                    end else if (!v[owner]) begin
                        idle++;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        if (idle == TO) begin locked = 0; last_owner = owner; exp_to = 1; idle = 0; end
`endif
                    end
                end else begin
                    idle = 0;
                    for (int i = 1; i <= N; i++) begin
                        k = (last_owner + i) % N;
                        if (v[k] && !locked) begin locked = 1; owner = k; end
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each downstream transfer, checks hold stability
    initial begin : monitor
        logic [N-1:0] prev_g = '0;
        logic         prev_stall = 1'b0;
        logic [7:0]   prev_d = '0;
        logic [7:0]   exp;
        forever begin
            @(negedge clk);
            if (prev_stall) check("hold_data", 32'(tx_data), 32'(prev_d));
            prev_stall = tx_vld && !tx_rdy && !rst;
            prev_d = tx_data;
            if (tx_vld && tx_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_byte: got 0x%0h with no expected byte (cycle %0d)", tx_data, cyc);
                end else begin
                    exp = sb.pop_front();
                    check("tx_data", 32'(tx_data), 32'(exp));
                end
                olog_d.push_back(tx_data);
                olog_c.push_back(cyc);
            end
            if (grant != prev_g) begin
                glog_v.push_back(grant);
                glog_c.push_back(cyc);
            end
            prev_g = grant;
        end
    end

    task automatic push_byte(input int s, input logic [7:0] b, input logic last);
        pkt_q[s].push_back({last, b});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  n = 0;
        bit  done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (grant == '0) && !tx_vld && (sb.size() == 0) && queues_empty();
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: not idle after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_glog(input string name, input int cnt, input int budget);
        int n = 0;
        while (glog_v.size() < cnt && n < budget) begin @(negedge clk); n++; end
        if (glog_v.size() < cnt) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: %0d grant changes seen, %0d required", name, glog_v.size(), cnt);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int s = 0; s < N; s++) pkt_q[s].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] pk [5];
        logic [7:0] held;
        int         c0, n, pulses;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_src_rdy", 32'(src_rdy), 32'(0));
        check("rst_tx_vld", 32'(tx_vld), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));

        // Three-byte packet from source 0 with the sink always ready
        olog_d.delete(); olog_c.delete();
        push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!src_vld[0] && n < 10);
        c0 = cyc;
        n = 0;
        while (olog_d.size() < 3 && n < 30) begin @(negedge clk); n++; end
        check("t1_count", 32'(olog_d.size()), 32'(3));
        if (olog_d.size() >= 3) begin
            check("t1_b0", 32'(olog_d[0]), 32'h41);
            check("t1_b1", 32'(olog_d[1]), 32'h42);
            check("t1_b2", 32'(olog_d[2]), 32'h43);
            check("t1_lat", 32'(olog_c[0]), 32'(c0 + 2));
            check("t1_c1", 32'(olog_c[1]), 32'(c0 + 3));
            check("t1_c2", 32'(olog_c[2]), 32'(c0 + 4));
        end
        wait_idle("t1_drain", 100);

        // Reset while a byte sits in the output register
        force_low = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(0, 8'($urandom), 1'(i == 4));
        n = 0;
        while (!tx_vld && n < 20) begin @(negedge clk); n++; end
        check("t2_buffered", 32'(tx_vld), 32'(1));
        force_low = 1'b0;
        pulse_reset();
        check("t2_vld_after_rst", 32'(tx_vld), 32'(0));
        check("t2_grant_after_rst", 32'(grant), 32'(0));
        glog_v.delete(); glog_c.delete();
        push_byte(3, 8'h33, 1'b1); push_byte(0, 8'h00, 1'b1);
        wait_glog("t2_grant", 1, 30);
        if (glog_v.size() >= 1) check("t2_src0_first", 32'(glog_v[0]), 32'b0001);
        wait_idle("t2_drain", 100);

        // Sources 1 and 3 request together right after reset
        pulse_reset();
        glog_v.delete(); glog_c.delete();
        push_byte(1, 8'h10, 1'b0); push_byte(1, 8'h11, 1'b1);
        push_byte(3, 8'h30, 1'b0); push_byte(3, 8'h31, 1'b1);
        wait_glog("t3_grants", 3, 40);
        if (glog_v.size() >= 3) begin
            check("t3_first", 32'(glog_v[0]), 32'b0010);
            check("t3_gap", 32'(glog_v[1]), 32'b0000);
            check("t3_second", 32'(glog_v[2]), 32'b1000);
            check("t3_one_arb_cycle", 32'(glog_c[2] - glog_c[1]), 32'(1));
        end
        wait_idle("t3_drain", 100);

        // Sink stalls for 10 cycles mid-packet
        olog_d.delete(); olog_c.delete();
        for (int i = 0; i < 5; i++) begin
            pk[i] = 8'($urandom);
            push_byte(0, pk[i], 1'(i == 4));
        end
        n = 0;
        while (olog_d.size() < 2 && n < 30) begin @(negedge clk); n++; end
        force_low = 1'b1;
        @(negedge clk);
        held = tx_data;
        for (int i = 0; i < 10; i++) begin
            check("t4_vld_stall", 32'(tx_vld), 32'(1));
            check("t4_data_stall", 32'(tx_data), 32'(held));
            check("t4_rdy_stall", 32'(src_rdy[0]), 32'(0));
            @(negedge clk);
        end
        force_low = 1'b0;
        wait_idle("t4_drain", 100);
        check("t4_count", 32'(olog_d.size()), 32'(5));
        if (olog_d.size() == 5)
            for (int i = 0; i < 5; i++) check("t4_order", 32'(olog_d[i]), 32'(pk[i]));

        // Owner 2 goes quiet mid-packet while source 0 waits
        push_byte(2, 8'h20, 1'b0); push_byte(2, 8'h21, 1'b0); push_byte(2, 8'h22, 1'b1);
        n = 0;
        while (grant != 4'b0100 && n < 20) begin @(negedge clk); n++; end
        hold[2] = 1'b1;
        push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
        @(negedge clk);
        for (int i = 0; i < HOLD_CYC; i++) begin
            @(negedge clk);
            check("t5_grant_kept", 32'(grant), 32'b0100);
            check("t5_src0_blocked", 32'(src_rdy[0]), 32'(0));
        end
        hold[2] = 1'b0;
        wait_idle("t5_drain", 100);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Owner 1 never sends last; the lock is forced open
        glog_v.delete(); glog_c.delete();
        push_byte(1, 8'h5a, 1'b0);
        push_byte(3, 8'h3c, 1'b1);
        pulses = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (timeout) pulses++;
        end while (grant != 4'b1000 && n < 60);
        check("t6_pulses", 32'(pulses), 32'(1));
        if (glog_v.size() >= 3) begin
            check("t6_first", 32'(glog_v[0]), 32'b0010);
            check("t6_released", 32'(glog_v[1]), 32'b0000);
            check("t6_next", 32'(glog_v[2]), 32'b1000);
        end else begin
            check("t6_grant_changes", 32'(glog_v.size()), 32'(3));
        end
        wait_idle("t6_drain", 100);
`else
        pulses = 0;
`endif

        // Randomized packets with source gaps and sink back-pressure
        gap_pct = 25;
        rdy_low_pct = 30;
        for (int p = 0; p < 150; p++) begin
            int s, len;
            s = int'($urandom_range(N - 1));
            len = int'($urandom_range(5, 1));
            for (int i = 0; i < len; i++) push_byte(s, 8'($urandom), 1'(i == len - 1));
            repeat ($urandom_range(6)) @(negedge clk);
        end
        wait_idle("random_drain", 8000);
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
